instruction_decode_pipe: RTL

- Parametrised decode stage: register file, opcode decode, sign/zero extension, jump target, and a registered ID/EX boundary.
- Adds load-use hazard detection with stall generation, flush/bubble injection, and write-to-read bypass in the register file.
- Sits between the IF/ID register and the execute stage; all data and control outputs are registered with 1-cycle latency.

---
 rtl/instruction_decode_pkg.sv | 37 +++
 rtl/instruction_decode_pipe_if.sv | 65 ++++++
 rtl/regfile_bypass.sv | 62 ++++++
 rtl/instruction_decode_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg
//   Shared definitions for the instruction decode stage: opcode values,
//   the control-signal bundle carried across the ID/EX boundary, the
//   all-zero bubble bundle and a helper that identifies the opcodes
//   whose immediate is zero-extended.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // Control bundle. The ALU operation code is kept outside the struct
  // because its width is a parameter of the stage.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic jump;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_dst;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/instruction_decode_pipe_if.sv
// instruction_decode_pipe_if
//   Bundles the decode stage's upstream inputs (IF/ID entry, flush, WB
//   write port) and its downstream outputs (ID/EX entry, stall request).
//   master : the surrounding pipeline / testbench side.
//   slave  : the decode stage itself.
//
// Handshake: upstream presents an instruction with in_valid=1. The stage
// accepts it on a rising clock edge unless stall_out=1 in that cycle, in
// which case upstream must hold instruction/pc_incrementado/in_valid
// unchanged for the next cycle (stall_out acts as an inverted ready).
// Downstream sees one ID/EX entry per cycle, qualified by out_valid; there
// is no back-pressure from execute.
interface instruction_decode_pipe_if #(
  parameter int B       = 32,
  parameter int W       = 5,
  parameter int ALUOP_W = 6
);
  // upstream -> decode
  logic               in_valid;
  logic [B-1:0]       instruction;
  logic [B-1:0]       pc_incrementado;
  logic               flush;
  logic               RegWrite;
  logic [W-1:0]       address_write;
  logic [B-1:0]       data_write;
  // decode -> pipeline
  logic               stall_out;
  logic               out_valid;
  logic [B-1:0]       reg_data1;
  logic [B-1:0]       reg_data2;
  logic [B-1:0]       imm_ext;
  logic [W-1:0]       rs;
  logic [W-1:0]       rt;
  logic [W-1:0]       rd;
  logic [B-1:0]       pc_jump;
  logic               wb_RegWrite_out;
  logic               wb_MemtoReg_out;
  logic               m_Jump_out;
  logic               m_Branch_out;
  logic               m_MemRead_out;
  logic               m_MemWrite_out;
  logic               ex_RegDst_out;
  logic               ex_ALUSrc_out;
  logic [ALUOP_W-1:0] ex_ALUOp_out;

  modport master (
    output in_valid, instruction, pc_incrementado, flush,
           RegWrite, address_write, data_write,
    input  stall_out, out_valid, reg_data1, reg_data2, imm_ext,
           rs, rt, rd, pc_jump,
           wb_RegWrite_out, wb_MemtoReg_out, m_Jump_out, m_Branch_out,
           m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out,
           ex_ALUOp_out
  );

  modport slave (
    input  in_valid, instruction, pc_incrementado, flush,
           RegWrite, address_write, data_write,
    output stall_out, out_valid, reg_data1, reg_data2, imm_ext,
           rs, rt, rd, pc_jump,
           wb_RegWrite_out, wb_MemtoReg_out, m_Jump_out, m_Branch_out,
           m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out,
           ex_ALUOp_out
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   2**W x B register file, two combinational read ports, one write port.
//   Register 0 is hard-wired to zero. A read of the address being written
//   in the same cycle returns the write data (write-to-read bypass), so the
//   decode stage never sees a stale value from the writeback stage.
// Ports:
//   clk, reset         clock, synchronous active-low clear of all entries
//   we_i/waddr_i/wdata_i  write port (committed at the rising edge)
//   raddr1_i/raddr2_i  read addresses
//   rdata1_o/rdata2_o  read data (bypassed)
module regfile_bypass #(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [W-1:0] waddr_i,
  input  logic [B-1:0] wdata_i,
  input  logic [W-1:0] raddr1_i,
  input  logic [W-1:0] raddr2_i,
  output logic [B-1:0] rdata1_o,
  output logic [B-1:0] rdata2_o
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] mem_q [DEPTH];
  logic         wr_live;

  // A write to r0 is dropped, so it must not be bypassed either.
  assign wr_live = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_live) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (wr_live && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = mem_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (wr_live && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/instruction_decode_pipe.sv
// instruction_decode_pipe
//   Decode stage between IF/ID and execute: register file read with
//   writeback bypass, opcode decode, immediate extension, jump target,
//   load-use hazard detection and a registered ID/EX boundary.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (clears ID/EX and the register file)
//   bus    slave side of instruction_decode_pipe_if (IF/ID entry, flush,
//          WB write port in; ID/EX entry and stall_out out)
// All ID/EX outputs have one cycle of latency; stall_out is combinational.
module instruction_decode_pipe
  import instruction_decode_pkg::*;
#(
  parameter int B       = 32,
  parameter int W       = 5,
  parameter int ALUOP_W = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_decode_pipe_if.slave  bus
);

  // Instruction fields (field positions assume a 32-bit instruction).
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [W-1:0] rs_in;
  logic [W-1:0] rt_in;
  logic [W-1:0] rd_in;
  logic [B-1:0] rf_data1;
  logic [B-1:0] rf_data2;

  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign rs_in  = W'(bus.instruction[25:21]);
  assign rt_in  = W'(bus.instruction[20:16]);
  assign rd_in  = W'(bus.instruction[15:11]);

  regfile_bypass #(.B(B), .W(W)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (bus.RegWrite),
    .waddr_i  (bus.address_write),
    .wdata_i  (bus.data_write),
    .raddr1_i (rs_in),
    .raddr2_i (rt_in),
    .rdata1_o (rf_data1),
    .rdata2_o (rf_data2)
  );

  // ID/EX state
  logic               out_valid_q, out_valid_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic [B-1:0]       data1_q, data1_d;
  logic [B-1:0]       data2_q, data2_d;
  logic [B-1:0]       imm_q, imm_d;
  logic [W-1:0]       rs_q, rs_d;
  logic [W-1:0]       rt_q, rt_d;
  logic [W-1:0]       rd_q, rd_d;
  logic [B-1:0]       pc_jump_q, pc_jump_d;

  // Only the segment above the 256 MB jump region is taken from the PC.
  logic unused_pc_low;
  assign unused_pc_low = ^bus.pc_incrementado[27:0];

  // Opcode decode
  ctrl_t dec_ctrl;
  always_comb begin
    dec_ctrl = BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ:  dec_ctrl.branch = 1'b1;
      OP_J:    dec_ctrl.jump   = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      default: dec_ctrl = BUBBLE;
    endcase
  end

  // Load-use hazard: the load sitting in ID/EX writes a register that the
  // instruction in decode reads. r0 never creates a dependency, and a
  // flushed instruction has nothing to wait for.
  logic hazard;
  assign hazard = reset
                & bus.in_valid
                & out_valid_q
                & ctrl_q.mem_read
                & ((rt_q == rs_in) | (rt_q == rt_in))
                & (rt_q != '0)
                & ~bus.flush;

  assign bus.stall_out = hazard;

  // Next ID/EX entry: a bubble (everything zero) unless a live instruction
  // is accepted this cycle.
  logic load_bubble;
  assign load_bubble = bus.flush | hazard | ~bus.in_valid;

  always_comb begin
    out_valid_d = 1'b0;
    ctrl_d      = BUBBLE;
    alu_op_d    = '0;
    data1_d     = '0;
    data2_d     = '0;
    imm_d       = '0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    pc_jump_d   = '0;
    if (!load_bubble) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      alu_op_d    = (opcode == OP_RTYPE) ? ALUOP_W'(funct) : ALUOP_W'(opcode);
      data1_d     = rf_data1;
      data2_d     = rf_data2;
      imm_d       = is_zero_ext(opcode)
                    ? {{(B-16){1'b0}}, bus.instruction[15:0]}
                    : {{(B-16){bus.instruction[15]}}, bus.instruction[15:0]};
      rs_d        = rs_in;
      rt_d        = rt_in;
      rd_d        = rd_in;
      pc_jump_d   = {bus.pc_incrementado[B-1:28], bus.instruction[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= BUBBLE;
      alu_op_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      pc_jump_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      alu_op_q    <= alu_op_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      pc_jump_q   <= pc_jump_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.reg_data1       = data1_q;
  assign bus.reg_data2       = data2_q;
  assign bus.imm_ext         = imm_q;
  assign bus.rs              = rs_q;
  assign bus.rt              = rt_q;
  assign bus.rd              = rd_q;
  assign bus.pc_jump         = pc_jump_q;
  assign bus.wb_RegWrite_out = ctrl_q.reg_write;
  assign bus.wb_MemtoReg_out = ctrl_q.mem_to_reg;
  assign bus.m_Jump_out      = ctrl_q.jump;
  assign bus.m_Branch_out    = ctrl_q.branch;
  assign bus.m_MemRead_out   = ctrl_q.mem_read;
  assign bus.m_MemWrite_out  = ctrl_q.mem_write;
  assign bus.ex_RegDst_out   = ctrl_q.reg_dst;
  assign bus.ex_ALUSrc_out   = ctrl_q.alu_src;
  assign bus.ex_ALUOp_out    = alu_op_q;

endmodule
